// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the K&S 16-bit datapath.
// Drives every datapath enable/select line and the RAM write strobe.
// Optional feature: define CTRL_RETIRE_CNT_EN to add the instr_retired
// counter output (CNT_W bits wide).

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    reg_zero,
  input  logic                    reg_neg,
  input  logic                    reg_ov,
  input  logic                    reg_sov,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halted
`ifdef CTRL_RETIRE_CNT_EN
  ,output logic [CNT_W-1:0]       instr_retired
`endif
);

  // Four-bit encoding leaves spare codes; any of them falls back to FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_LOAD   = 4'd2,
    S_STORE  = 4'd3,
    S_ALU    = 4'd4,
    S_BRANCH = 4'd5,
    S_NOP    = 4'd6,
    S_HALT   = 4'd7
  } state_t;

  state_t state_q, state_d;

  logic       branch_c;
  logic       pc_enable_c;
  logic       ir_enable_c;
  logic       addr_sel_c;
  logic       c_sel_c;
  logic [1:0] operation_c;
  logic       write_reg_enable_c;
  logic       flags_reg_enable_c;
  logic       ram_write_enable_c;
  logic       halted_c;

  // reg_sov is part of the flag bundle but no branch condition uses it.
  logic unused_sigs;
  assign unused_sigs = reg_sov ^ (CNT_W > 0);

  // State register; reset parks the controller in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and Moore output decode.
  always_comb begin
    state_d            = S_FETCH;
    branch_c           = 1'b0;
    pc_enable_c        = 1'b0;
    ir_enable_c        = 1'b0;
    addr_sel_c         = 1'b0;
    c_sel_c            = 1'b0;
    operation_c        = 2'b00;
    write_reg_enable_c = 1'b0;
    flags_reg_enable_c = 1'b0;
    ram_write_enable_c = 1'b0;
    halted_c           = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_enable_c = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                           state_d = S_LOAD;
          I_STORE:                          state_d = S_STORE;
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE: state_d = S_ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:           state_d = S_BRANCH;
          I_HALT:                           state_d = S_HALT;
          default:                          state_d = S_NOP;
        endcase
      end
      S_LOAD: begin
        addr_sel_c         = 1'b1;
        c_sel_c            = 1'b0;
        write_reg_enable_c = 1'b1;
        pc_enable_c        = 1'b1;
        state_d            = S_FETCH;
      end
      S_STORE: begin
        addr_sel_c         = 1'b1;
        ram_write_enable_c = 1'b1;
        pc_enable_c        = 1'b1;
        state_d            = S_FETCH;
      end
      S_ALU: begin
        c_sel_c            = 1'b1;
        write_reg_enable_c = 1'b1;
        pc_enable_c        = 1'b1;
        state_d            = S_FETCH;
        case (decoded_instruction)
          I_ADD: begin
            operation_c        = 2'b01;
            flags_reg_enable_c = 1'b1;
          end
          I_SUB: begin
            operation_c        = 2'b10;
            flags_reg_enable_c = 1'b1;
          end
          I_AND: begin
            operation_c        = 2'b11;
            flags_reg_enable_c = 1'b1;
          end
          I_OR: begin
            operation_c        = 2'b00;
            flags_reg_enable_c = 1'b1;
          end
          // MOVE is a|a through the OR path and must not disturb the flags.
          default: begin
            operation_c        = 2'b00;
            flags_reg_enable_c = 1'b0;
          end
        endcase
      end
      S_BRANCH: begin
        addr_sel_c  = 1'b1;
        pc_enable_c = 1'b1;
        state_d     = S_FETCH;
        case (decoded_instruction)
          I_BRANCH: branch_c = 1'b1;
          I_BZERO:  branch_c = reg_zero;
          I_BNZERO: branch_c = ~reg_zero;
          I_BNEG:   branch_c = reg_neg;
          I_BNNEG:  branch_c = ~reg_neg;
          I_BOV:    branch_c = reg_ov;
          I_BNOV:   branch_c = ~reg_ov;
          default:  branch_c = 1'b0;
        endcase
      end
      S_NOP: begin
        pc_enable_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
        state_d  = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset masks every output immediately, independent of the clock.
  assign branch           = branch_c           & ~rst;
  assign pc_enable        = pc_enable_c        & ~rst;
  assign ir_enable        = ir_enable_c        & ~rst;
  assign addr_sel         = addr_sel_c         & ~rst;
  assign c_sel            = c_sel_c            & ~rst;
  assign operation        = operation_c        & {2{~rst}};
  assign write_reg_enable = write_reg_enable_c & ~rst;
  assign flags_reg_enable = flags_reg_enable_c & ~rst;
  assign ram_write_enable = ram_write_enable_c & ~rst;
  assign halted           = halted_c           & ~rst;

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_c;

  // One retirement per executed instruction; HALT retires on entry.
  always_comb begin
    retire_c = pc_enable_c | ((state_q == S_DECODE) && (state_d == S_HALT));
    cnt_d    = cnt_q;
    if (retire_c) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Retired-instruction counter register, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_retired = cnt_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit. Counter checks are compiled in when
// CTRL_RETIRE_CNT_EN is defined (counter width fixed at 4 here).
module tb_control_unit;
  import k_and_s_pkg::*;

  localparam int CNT_W = 4;

  logic                    clk;
  logic                    rst;
  decoded_instruction_type decoded_instruction;
  logic                    reg_zero, reg_neg, reg_ov, reg_sov;
  logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable, flags_reg_enable, ram_write_enable, halted;
`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0]        instr_retired;
`endif

  control_unit #(.CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .decoded_instruction (decoded_instruction),
    .reg_zero            (reg_zero),
    .reg_neg             (reg_neg),
    .reg_ov              (reg_ov),
    .reg_sov             (reg_sov),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halted              (halted)
`ifdef CTRL_RETIRE_CNT_EN
    ,.instr_retired      (instr_retired)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [CNT_W-1:0] exp_cnt;

  // Output bundle: {branch,pc_en,ir_en,addr_sel,c_sel,op[1:0],wr_reg,flags_en,ram_we,halted}
  logic [10:0] obs;
  assign obs = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                write_reg_enable, flags_reg_enable, ram_write_enable, halted};

  function automatic logic [10:0] vec(input logic br, input logic pc, input logic ir,
                                      input logic as, input logic cs, input logic [1:0] op,
                                      input logic wr, input logic fr, input logic rw,
                                      input logic h);
    return {br, pc, ir, as, cs, op, wr, fr, rw, h};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef CTRL_RETIRE_CNT_EN
    check(tag, 32'(instr_retired), 32'(exp_cnt));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Entered at a negedge with the controller in FETCH; leaves it in FETCH.
  task automatic run_instr(input string tag, input decoded_instruction_type ins,
                           input logic z, input logic n, input logic o,
                           input logic [10:0] exp_exec);
    decoded_instruction = ins;
    reg_zero = z;
    reg_neg  = n;
    reg_ov   = o;
    reg_sov  = ~reg_sov;
    #1;
    check({tag, "_fetch"}, 32'(obs), 32'(vec(0,0,1,0,0,2'b00,0,0,0,0)));
    @(negedge clk);
    check({tag, "_decode"}, 32'(obs), 32'd0);
    @(negedge clk);
    check(tag, 32'(obs), 32'(exp_exec));
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    #1;
    check_cnt({tag, "_cnt"});
  endtask

  initial begin
    rst = 1'b1;
    decoded_instruction = I_NOP;
    reg_zero = 0; reg_neg = 0; reg_ov = 0; reg_sov = 0;
    exp_cnt = '0;

    // Reset held: every output low, even in FETCH.
    @(negedge clk);
    check("rst_outs", 32'(obs), 32'd0);
    check_cnt("rst_cnt");
    @(negedge clk);
    rst = 1'b0;

    // First instruction after reset: NOP.
    run_instr("nop0", I_NOP, 0, 0, 0, vec(0,1,0,0,0,2'b00,0,0,0,0));

    // ALU group.
    run_instr("add",  I_ADD,  0, 0, 0, vec(0,1,0,0,1,2'b01,1,1,0,0));
    run_instr("sub",  I_SUB,  0, 0, 0, vec(0,1,0,0,1,2'b10,1,1,0,0));
    run_instr("and",  I_AND,  0, 0, 0, vec(0,1,0,0,1,2'b11,1,1,0,0));
    run_instr("or",   I_OR,   0, 0, 0, vec(0,1,0,0,1,2'b00,1,1,0,0));
    run_instr("move", I_MOVE, 0, 0, 0, vec(0,1,0,0,1,2'b00,1,0,0,0));

    // Memory group.
    run_instr("load",  I_LOAD,  0, 0, 0, vec(0,1,0,1,0,2'b00,1,0,0,0));
    run_instr("store", I_STORE, 0, 0, 0, vec(0,1,0,1,0,2'b00,0,0,1,0));

    // Branches, taken and not taken.
    run_instr("br",       I_BRANCH, 0, 0, 0, vec(1,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bz_t",     I_BZERO,  1, 0, 0, vec(1,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bz_n",     I_BZERO,  0, 1, 1, vec(0,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bnz_t",    I_BNZERO, 0, 0, 0, vec(1,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bnz_n",    I_BNZERO, 1, 0, 0, vec(0,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bneg_t",   I_BNEG,   0, 1, 0, vec(1,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bneg_n",   I_BNEG,   1, 0, 1, vec(0,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bnneg_t",  I_BNNEG,  1, 0, 1, vec(1,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bnneg_n",  I_BNNEG,  0, 1, 0, vec(0,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bov_t",    I_BOV,    0, 0, 1, vec(1,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bov_n",    I_BOV,    1, 1, 0, vec(0,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bnov_t",   I_BNOV,   1, 1, 0, vec(1,1,0,1,0,2'b00,0,0,0,0));
    run_instr("bnov_n",   I_BNOV,   0, 0, 1, vec(0,1,0,1,0,2'b00,0,0,0,0));

    // Reset asserted in the middle of a STORE execute cycle.
    decoded_instruction = I_STORE;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_store", 32'(obs), 32'(vec(0,1,0,1,0,2'b00,0,0,1,0)));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_outs", 32'(obs), 32'd0);
    exp_cnt = '0;
    check_cnt("mid_rst_cnt");
    @(negedge clk);
    rst = 1'b0;
    run_instr("nop_mid", I_NOP, 0, 0, 0, vec(0,1,0,0,0,2'b00,0,0,0,0));

    // HALT: halted from the execute cycle on, no strobes for 20 cycles.
    decoded_instruction = I_HALT;
    #1;
    check("halt_fetch", 32'(obs), 32'(vec(0,0,1,0,0,2'b00,0,0,0,0)));
    @(negedge clk);
    check("halt_decode", 32'(obs), 32'd0);
    exp_cnt = exp_cnt + 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("halt_%0d", i), 32'(obs), 32'(vec(0,0,0,0,0,2'b00,0,0,0,1)));
      check_cnt("halt_cnt");
    end
    #2 rst = 1'b1;
    #1;
    check("halt_rst_outs", 32'(obs), 32'd0);
    exp_cnt = '0;
    check_cnt("halt_rst_cnt");
    @(negedge clk);
    rst = 1'b0;
    run_instr("nop_after_halt", I_NOP, 0, 0, 0, vec(0,1,0,0,0,2'b00,0,0,0,0));

`ifdef CTRL_RETIRE_CNT_EN
    // Counter wrap: 15 more NOPs bring a 4-bit count from 1 back to 0.
    for (int i = 0; i < 15; i++) begin
      run_instr("nop_wrap", I_NOP, 0, 0, 0, vec(0,1,0,0,0,2'b00,0,0,0,0));
    end
    check("wrap_zero", 32'(instr_retired), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
